// File: rtl/thr_pkg.sv
// Shared types for the RGB565 threshold configuration controller:
// channel widths, register addresses, the threshold set struct and FSM states.
package thr_pkg;

  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;

  localparam logic [2:0] ADDR_R_MIN = 3'd0;
  localparam logic [2:0] ADDR_R_MAX = 3'd1;
  localparam logic [2:0] ADDR_G_MIN = 3'd2;
  localparam logic [2:0] ADDR_G_MAX = 3'd3;
  localparam logic [2:0] ADDR_B_MIN = 3'd4;
  localparam logic [2:0] ADDR_B_MAX = 3'd5;

  typedef struct packed {
    logic [R_W-1:0] r_min;
    logic [R_W-1:0] r_max;
    logic [G_W-1:0] g_min;
    logic [G_W-1:0] g_max;
    logic [B_W-1:0] b_min;
    logic [B_W-1:0] b_max;
  } thr_set_t;

  typedef enum logic [1:0] {IDLE, PEND, COMMIT} state_t;

  // Red/blue registers are 5 bits wide, so data bit 5 is dropped for them.
  function automatic thr_set_t apply_write(input thr_set_t s, input logic [2:0] addr,
                                           input logic [5:0] data);
    thr_set_t s_out;
    s_out = s;
    case (addr)
      ADDR_R_MIN: s_out.r_min = data[R_W-1:0];
      ADDR_R_MAX: s_out.r_max = data[R_W-1:0];
      ADDR_G_MIN: s_out.g_min = data[G_W-1:0];
      ADDR_G_MAX: s_out.g_max = data[G_W-1:0];
      ADDR_B_MIN: s_out.b_min = data[B_W-1:0];
      ADDR_B_MAX: s_out.b_max = data[B_W-1:0];
      default:    s_out = s;
    endcase
    return s_out;
  endfunction

endpackage

// File: rtl/thr_frame_counter.sv
// Frame-start detection from vs and per-frame foreground pixel counting
// with a saturating accumulator reported at every frame start.
module thr_frame_counter #(
  parameter int CNT_W  = 20,
  parameter bit VS_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vs,
  input  logic             thr_de,
  input  logic             thr_data,
  output logic             fs,
  output logic [CNT_W-1:0] fg_count,
  output logic             fg_valid
);

  localparam bit VS_IDLE = !VS_POL;

  logic             vs_d1;
  logic             vs_d2;
  logic             pix;
  logic [CNT_W-1:0] acc;

  assign pix = thr_de & thr_data;
  assign fs  = (vs_d1 == VS_POL) && (vs_d2 == VS_IDLE);

  // A pixel landing in the fs cycle belongs to the new frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_d1    <= VS_IDLE;
      vs_d2    <= VS_IDLE;
      acc      <= '0;
      fg_count <= '0;
      fg_valid <= 1'b0;
    end else begin
      vs_d1    <= vs;
      vs_d2    <= vs_d1;
      fg_valid <= fs;
      if (fs) begin
        fg_count <= acc;
        acc      <= CNT_W'(pix);
      end else if (pix && (acc != '1)) begin
        acc <= acc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/thr_cfg_ctrl.sv
// Shadow/active threshold configuration with frame-aligned commit.
// Optional THR_MINMAX_CHECK_EN rejects per-channel min>max pairs at commit.
module thr_cfg_ctrl
  import thr_pkg::*;
#(
  parameter logic [R_W-1:0] R_MIN_RST = 5'd0,
  parameter logic [R_W-1:0] R_MAX_RST = 5'd6,
  parameter logic [G_W-1:0] G_MIN_RST = 6'd0,
  parameter logic [G_W-1:0] G_MAX_RST = 6'd12,
  parameter logic [B_W-1:0] B_MIN_RST = 5'd0,
  parameter logic [B_W-1:0] B_MAX_RST = 5'd6,
  parameter bit             VS_POL    = 1'b1,
  parameter int             CNT_W     = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_addr,
  input  logic [5:0]       cfg_data,
  input  logic             vs,
  input  logic             thr_de,
  input  logic             thr_data,
  output logic [R_W-1:0]   r_min,
  output logic [R_W-1:0]   r_max,
  output logic [G_W-1:0]   g_min,
  output logic [G_W-1:0]   g_max,
  output logic [B_W-1:0]   b_min,
  output logic [B_W-1:0]   b_max,
  output logic             cfg_pending,
  output logic             cfg_err,
  output logic [CNT_W-1:0] fg_count,
  output logic             fg_valid
);

  localparam thr_set_t RST_SET = '{
    r_min: R_MIN_RST, r_max: R_MAX_RST,
    g_min: G_MIN_RST, g_max: G_MAX_RST,
    b_min: B_MIN_RST, b_max: B_MAX_RST
  };

  thr_set_t shadow;
  thr_set_t active;
  thr_set_t shadow_next;
  thr_set_t commit_set;
  state_t   state;
  logic     accept;
  logic     reg_write;
  logic     fs;

  assign accept    = cfg_valid & cfg_ready;
  assign reg_write = accept && (cfg_addr <= ADDR_B_MAX);

  thr_frame_counter #(
    .CNT_W  (CNT_W),
    .VS_POL (VS_POL)
  ) u_frame_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .vs       (vs),
    .thr_de   (thr_de),
    .thr_data (thr_data),
    .fs       (fs),
    .fg_count (fg_count),
    .fg_valid (fg_valid)
  );

  // A write merged in the fs cycle is committed with the rest of the set.
  always_comb begin
    shadow_next = accept ? apply_write(shadow, cfg_addr, cfg_data) : shadow;
  end

`ifdef THR_MINMAX_CHECK_EN
  logic reject;

  always_comb begin
    commit_set = shadow_next;
    reject     = 1'b0;
    if (shadow_next.r_min > shadow_next.r_max) begin
      commit_set.r_min = active.r_min;
      commit_set.r_max = active.r_max;
      reject           = 1'b1;
    end
    if (shadow_next.g_min > shadow_next.g_max) begin
      commit_set.g_min = active.g_min;
      commit_set.g_max = active.g_max;
      reject           = 1'b1;
    end
    if (shadow_next.b_min > shadow_next.b_max) begin
      commit_set.b_min = active.b_min;
      commit_set.b_max = active.b_max;
      reject           = 1'b1;
    end
  end
`else
  always_comb begin
    commit_set = shadow_next;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      shadow      <= RST_SET;
      active      <= RST_SET;
      cfg_ready   <= 1'b1;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      shadow  <= shadow_next;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (reg_write) begin
            state       <= PEND;
            cfg_pending <= 1'b1;
          end
        end
        PEND: begin
          if (fs) begin
            active    <= commit_set;
            shadow    <= commit_set;
            state     <= COMMIT;
            cfg_ready <= 1'b0;
`ifdef THR_MINMAX_CHECK_EN
            cfg_err   <= reject;
`endif
          end
        end
        COMMIT: begin
          state       <= IDLE;
          cfg_ready   <= 1'b1;
          cfg_pending <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          cfg_ready   <= 1'b1;
          cfg_pending <= 1'b0;
        end
      endcase
    end
  end

  assign r_min = active.r_min;
  assign r_max = active.r_max;
  assign g_min = active.g_min;
  assign g_max = active.g_max;
  assign b_min = active.b_min;
  assign b_max = active.b_max;

endmodule

// File: tb/tb_thr_cfg_ctrl.sv
// Directed bench for thr_cfg_ctrl; expectations follow THR_MINMAX_CHECK_EN.
// A second instance with CNT_W=4 shares all inputs to observe saturation.
module tb_thr_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic [2:0] cfg_addr;
  logic [5:0] cfg_data;
  logic       vs;
  logic       thr_de;
  logic       thr_data;

  logic        cfg_ready, cfg_pending, cfg_err, fg_valid;
  logic [4:0]  r_min, r_max, b_min, b_max;
  logic [5:0]  g_min, g_max;
  logic [19:0] fg_count;

  logic        s_cfg_ready, s_cfg_pending, s_cfg_err, s_fg_valid;
  logic [4:0]  s_r_min, s_r_max, s_b_min, s_b_max;
  logic [5:0]  s_g_min, s_g_max;
  logic [3:0]  s_fg_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  thr_cfg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .vs(vs), .thr_de(thr_de), .thr_data(thr_data),
    .r_min(r_min), .r_max(r_max), .g_min(g_min), .g_max(g_max), .b_min(b_min), .b_max(b_max),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err), .fg_count(fg_count), .fg_valid(fg_valid)
  );

  thr_cfg_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(s_cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .vs(vs), .thr_de(thr_de), .thr_data(thr_data),
    .r_min(s_r_min), .r_max(s_r_max), .g_min(s_g_min), .g_max(s_g_max), .b_min(s_b_min),
    .b_max(s_b_max), .cfg_pending(s_cfg_pending), .cfg_err(s_cfg_err),
    .fg_count(s_fg_count), .fg_valid(s_fg_valid)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Raises vs for one cycle; returns at the negedge inside the fs cycle.
  task automatic vs_rise();
    vs = 1'b1;
    tick();
    vs = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++; if (r_min !== 5'd0) begin n_err++; $display("[TB] FAIL rst_r_min: got %0d want 0", r_min); end
    n_vec++; if (r_max !== 5'd6) begin n_err++; $display("[TB] FAIL rst_r_max: got %0d want 6", r_max); end
    n_vec++; if (g_min !== 6'd0) begin n_err++; $display("[TB] FAIL rst_g_min: got %0d want 0", g_min); end
    n_vec++; if (g_max !== 6'd12) begin n_err++; $display("[TB] FAIL rst_g_max: got %0d want 12", g_max); end
    n_vec++; if (b_min !== 5'd0) begin n_err++; $display("[TB] FAIL rst_b_min: got %0d want 0", b_min); end
    n_vec++; if (b_max !== 5'd6) begin n_err++; $display("[TB] FAIL rst_b_max: got %0d want 6", b_max); end
    n_vec++; if (cfg_pending !== 1'b0) begin n_err++; $display("[TB] FAIL rst_pending: got %b want 0", cfg_pending); end
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rst_ready: got %b want 1", cfg_ready); end
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("[TB] FAIL rst_err: got %b want 0", cfg_err); end
    n_vec++; if (fg_count !== 20'd0) begin n_err++; $display("[TB] FAIL rst_fg_count: got %0d want 0", fg_count); end
    n_vec++; if (fg_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_fg_valid: got %b want 0", fg_valid); end
    // first frame start reports a partial frame and is discarded
    vs_rise();
    tick();
    tick();
  endtask

  task automatic test_write_commit();
    cfg_valid = 1'b1; cfg_addr = 3'd3; cfg_data = 6'd20;
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("[TB] FAIL wc_ready: got %b want 1", cfg_ready); end
    tick();
    cfg_valid = 1'b0;
    n_vec++; if (cfg_pending !== 1'b1) begin n_err++; $display("[TB] FAIL wc_pending: got %b want 1", cfg_pending); end
    n_vec++; if (g_max !== 6'd12) begin n_err++; $display("[TB] FAIL wc_gmax_early: got %0d want 12", g_max); end
    repeat (3) tick();
    n_vec++; if (g_max !== 6'd12) begin n_err++; $display("[TB] FAIL wc_gmax_hold: got %0d want 12", g_max); end
    n_vec++; if (cfg_pending !== 1'b1) begin n_err++; $display("[TB] FAIL wc_pending_hold: got %b want 1", cfg_pending); end
    vs_rise();
    n_vec++; if (g_max !== 6'd12) begin n_err++; $display("[TB] FAIL wc_gmax_fs: got %0d want 12", g_max); end
    tick();
    n_vec++; if (g_max !== 6'd20) begin n_err++; $display("[TB] FAIL wc_gmax_new: got %0d want 20", g_max); end
    n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("[TB] FAIL wc_ready_commit: got %b want 0", cfg_ready); end
    tick();
    n_vec++; if (cfg_pending !== 1'b0) begin n_err++; $display("[TB] FAIL wc_pending_done: got %b want 0", cfg_pending); end
    n_vec++; if (g_max !== 6'd20) begin n_err++; $display("[TB] FAIL wc_gmax_keep: got %0d want 20", g_max); end
  endtask

  task automatic test_pixel_count();
    int pulses;
    thr_de = 1'b1; thr_data = 1'b1;
    repeat (37) tick();
    thr_de = 1'b0; thr_data = 1'b1;
    repeat (10) tick();
    thr_de = 1'b1; thr_data = 1'b0;
    repeat (5) tick();
    thr_de = 1'b0; thr_data = 1'b0;
    vs_rise();
    pulses = 0;
    if (fg_valid === 1'b1) pulses++;
    tick();
    n_vec++; if (fg_valid !== 1'b1) begin n_err++; $display("[TB] FAIL pc_valid: got %b want 1", fg_valid); end
    n_vec++; if (fg_count !== 20'd37) begin n_err++; $display("[TB] FAIL pc_count: got %0d want 37", fg_count); end
    n_vec++; if (s_fg_count !== 4'd15) begin n_err++; $display("[TB] FAIL pc_sat_count: got %0d want 15", s_fg_count); end
    for (int i = 0; i < 4; i++) begin
      if (fg_valid === 1'b1) pulses++;
      tick();
    end
    n_vec++; if (pulses != 1) begin n_err++; $display("[TB] FAIL pc_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_saturation();
    thr_de = 1'b1; thr_data = 1'b1;
    repeat (20) tick();
    thr_de = 1'b0; thr_data = 1'b0;
    vs_rise();
    thr_de = 1'b1; thr_data = 1'b1;
    tick();
    thr_de = 1'b0; thr_data = 1'b0;
    n_vec++; if (fg_count !== 20'd20) begin n_err++; $display("[TB] FAIL sat_wide: got %0d want 20", fg_count); end
    n_vec++; if (s_fg_count !== 4'd15) begin n_err++; $display("[TB] FAIL sat_narrow: got %0d want 15", s_fg_count); end
    n_vec++; if (s_fg_valid !== 1'b1) begin n_err++; $display("[TB] FAIL sat_valid: got %b want 1", s_fg_valid); end
    tick();
  endtask

  task automatic test_fs_restart();
    repeat (4) tick();
    vs_rise();
    tick();
    n_vec++; if (fg_count !== 20'd1) begin n_err++; $display("[TB] FAIL rs_count: got %0d want 1", fg_count); end
    n_vec++; if (s_fg_count !== 4'd1) begin n_err++; $display("[TB] FAIL rs_sat_count: got %0d want 1", s_fg_count); end
    n_vec++; if (fg_valid !== 1'b1) begin n_err++; $display("[TB] FAIL rs_valid: got %b want 1", fg_valid); end
    tick();
    n_vec++; if (fg_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rs_valid_drop: got %b want 0", fg_valid); end
  endtask

  task automatic test_back_to_back();
    cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_data = 6'd2;
    tick();
    cfg_valid = 1'b0;
    n_vec++; if (cfg_pending !== 1'b1) begin n_err++; $display("[TB] FAIL bb_pending: got %b want 1", cfg_pending); end
    vs_rise();
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("[TB] FAIL bb_ready_fs: got %b want 1", cfg_ready); end
    tick();
    n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("[TB] FAIL bb_ready_commit: got %b want 0", cfg_ready); end
    n_vec++; if (r_min !== 5'd2) begin n_err++; $display("[TB] FAIL bb_rmin: got %0d want 2", r_min); end
    cfg_valid = 1'b1; cfg_addr = 3'd1; cfg_data = 6'd11;
    tick();
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("[TB] FAIL bb_ready_after: got %b want 1", cfg_ready); end
    n_vec++; if (cfg_pending !== 1'b0) begin n_err++; $display("[TB] FAIL bb_pending_idle: got %b want 0", cfg_pending); end
    n_vec++; if (r_max !== 5'd6) begin n_err++; $display("[TB] FAIL bb_rmax_old: got %0d want 6", r_max); end
    tick();
    cfg_valid = 1'b0;
    n_vec++; if (cfg_pending !== 1'b1) begin n_err++; $display("[TB] FAIL bb_pending_again: got %b want 1", cfg_pending); end
    n_vec++; if (r_max !== 5'd6) begin n_err++; $display("[TB] FAIL bb_rmax_hold: got %0d want 6", r_max); end
    vs_rise();
    tick();
    n_vec++; if (r_max !== 5'd11) begin n_err++; $display("[TB] FAIL bb_rmax_new: got %0d want 11", r_max); end
    tick();
  endtask

  task automatic test_idle_fs_write();
    vs_rise();
    cfg_valid = 1'b1; cfg_addr = 3'd2; cfg_data = 6'd5;
    tick();
    cfg_valid = 1'b0;
    n_vec++; if (cfg_pending !== 1'b1) begin n_err++; $display("[TB] FAIL ifs_pending: got %b want 1", cfg_pending); end
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("[TB] FAIL ifs_ready: got %b want 1", cfg_ready); end
    n_vec++; if (g_min !== 6'd0) begin n_err++; $display("[TB] FAIL ifs_gmin_early: got %0d want 0", g_min); end
    repeat (2) tick();
    n_vec++; if (g_min !== 6'd0) begin n_err++; $display("[TB] FAIL ifs_gmin_hold: got %0d want 0", g_min); end
    vs_rise();
    tick();
    n_vec++; if (g_min !== 6'd5) begin n_err++; $display("[TB] FAIL ifs_gmin_new: got %0d want 5", g_min); end
    tick();
  endtask

  task automatic test_reserved_addr();
    cfg_valid = 1'b1; cfg_addr = 3'd6; cfg_data = 6'd63;
    tick();
    cfg_addr = 3'd7;
    tick();
    cfg_valid = 1'b0;
    n_vec++; if (cfg_pending !== 1'b0) begin n_err++; $display("[TB] FAIL rsv_pending: got %b want 0", cfg_pending); end
    vs_rise();
    tick();
    tick();
    n_vec++; if (r_min !== 5'd2) begin n_err++; $display("[TB] FAIL rsv_rmin: got %0d want 2", r_min); end
    n_vec++; if (r_max !== 5'd11) begin n_err++; $display("[TB] FAIL rsv_rmax: got %0d want 11", r_max); end
    n_vec++; if (g_min !== 6'd5) begin n_err++; $display("[TB] FAIL rsv_gmin: got %0d want 5", g_min); end
    n_vec++; if (g_max !== 6'd20) begin n_err++; $display("[TB] FAIL rsv_gmax: got %0d want 20", g_max); end
    n_vec++; if (b_max !== 5'd6) begin n_err++; $display("[TB] FAIL rsv_bmax: got %0d want 6", b_max); end
  endtask

  task automatic test_minmax();
    logic [4:0] exp_rmin;
    logic [4:0] exp_rmax;
    logic       exp_err;
`ifdef THR_MINMAX_CHECK_EN
    exp_rmin = 5'd2;  exp_rmax = 5'd11; exp_err = 1'b1;
`else
    exp_rmin = 5'd10; exp_rmax = 5'd3;  exp_err = 1'b0;
`endif
    cfg_valid = 1'b1;
    cfg_addr = 3'd0; cfg_data = 6'd10; tick();
    cfg_addr = 3'd1; cfg_data = 6'd3;  tick();
    cfg_addr = 3'd5; cfg_data = 6'h29; tick();
    cfg_addr = 3'd4; cfg_data = 6'h20; tick();
    cfg_valid = 1'b0;
    vs_rise();
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("[TB] FAIL mm_err_early: got %b want 0", cfg_err); end
    tick();
    n_vec++; if (cfg_err !== exp_err) begin n_err++; $display("[TB] FAIL mm_err: got %b want %b", cfg_err, exp_err); end
    n_vec++; if (r_min !== exp_rmin) begin n_err++; $display("[TB] FAIL mm_rmin: got %0d want %0d", r_min, exp_rmin); end
    n_vec++; if (r_max !== exp_rmax) begin n_err++; $display("[TB] FAIL mm_rmax: got %0d want %0d", r_max, exp_rmax); end
    n_vec++; if (b_max !== 5'd9) begin n_err++; $display("[TB] FAIL mm_bmax: got %0d want 9", b_max); end
    n_vec++; if (b_min !== 5'd0) begin n_err++; $display("[TB] FAIL mm_bmin_bit5: got %0d want 0", b_min); end
    tick();
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("[TB] FAIL mm_err_pulse: got %b want 0", cfg_err); end
    n_vec++; if (cfg_pending !== 1'b0) begin n_err++; $display("[TB] FAIL mm_pending: got %b want 0", cfg_pending); end
    vs_rise();
    tick();
    tick();
    n_vec++; if (r_min !== exp_rmin) begin n_err++; $display("[TB] FAIL mm_rmin_keep: got %0d want %0d", r_min, exp_rmin); end
    n_vec++; if (r_max !== exp_rmax) begin n_err++; $display("[TB] FAIL mm_rmax_keep: got %0d want %0d", r_max, exp_rmax); end
  endtask

  task automatic test_reset_mid_pend();
    cfg_valid = 1'b1; cfg_addr = 3'd3; cfg_data = 6'd33;
    tick();
    cfg_valid = 1'b0;
    n_vec++; if (cfg_pending !== 1'b1) begin n_err++; $display("[TB] FAIL rmp_pending: got %b want 1", cfg_pending); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++; if (g_max !== 6'd12) begin n_err++; $display("[TB] FAIL rmp_gmax: got %0d want 12", g_max); end
    n_vec++; if (g_min !== 6'd0) begin n_err++; $display("[TB] FAIL rmp_gmin: got %0d want 0", g_min); end
    n_vec++; if (b_max !== 5'd6) begin n_err++; $display("[TB] FAIL rmp_bmax: got %0d want 6", b_max); end
    n_vec++; if (cfg_pending !== 1'b0) begin n_err++; $display("[TB] FAIL rmp_pending_clr: got %b want 0", cfg_pending); end
    vs_rise();
    tick();
    tick();
    n_vec++; if (g_max !== 6'd12) begin n_err++; $display("[TB] FAIL rmp_gmax_after_fs: got %0d want 12", g_max); end
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = 3'd0; cfg_data = 6'd0;
    vs = 1'b0; thr_de = 1'b0; thr_data = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    test_reset();
    test_write_commit();
    test_pixel_count();
    test_saturation();
    test_fs_restart();
    test_back_to_back();
    test_idle_fs_write();
    test_reserved_addr();
    test_minmax();
    test_reset_mid_pend();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/thr_cfg_ctrl.md
Name: thr_cfg_ctrl

Overview:
- Run-time configuration and statistics controller for the RGB565 threshold stage.
- Holds shadow and active min/max thresholds per channel. Writes go to the shadow set through a valid/ready port.
- The shadow set is committed to the active set atomically at the next frame start (VS edge), so thresholds never change mid-frame.
- Counts foreground pixels (thr_data & thr_de) per frame and reports the total at each frame start for tuning.

Parameters:
- R_MIN_RST, 0, reset value of red min (5-bit)
- R_MAX_RST, 6, reset value of red max (5-bit)
- G_MIN_RST, 0, reset value of green min (6-bit)
- G_MAX_RST, 12, reset value of green max (6-bit)
- B_MIN_RST, 0, reset value of blue min (5-bit)
- B_MAX_RST, 6, reset value of blue max (5-bit)
- VS_POL, 1, active level of vs (1 = frame starts on vs rising edge, 0 = on falling edge)
- CNT_W, 20, width of the foreground pixel counter

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- cfg_valid  in  1  write request
- cfg_ready  out  1  write accepted when cfg_valid & cfg_ready
- cfg_addr  in  3  0=r_min 1=r_max 2=g_min 3=g_max 4=b_min 5=b_max, 6/7 reserved
- cfg_data  in  6  write data; bit5 ignored for red/blue
- vs  in  1  frame sync from the threshold stage output
- thr_de  in  1  data-enable from the threshold stage output
- thr_data  in  1  binary pixel from the threshold stage output
- r_min, r_max  out  5 each  active red thresholds
- g_min, g_max  out  6 each  active green thresholds
- b_min, b_max  out  5 each  active blue thresholds
- cfg_pending  out  1  shadow set differs from active set (a commit is awaited)
- cfg_err  out  1  one-cycle pulse, min>max rejected at commit
- fg_count  out  CNT_W  foreground pixel count of the last complete frame
- fg_valid  out  1  one-cycle pulse when fg_count updates

Behaviour:
- Reset (rst_n low at a clk edge):
  - Shadow and active sets load the *_RST parameters.
  - State returns to IDLE; cfg_pending=0, cfg_err=0, fg_count=0, fg_valid=0.
  - Pixel accumulator is cleared and cfg_ready=1.
  - The vs history register loads the inactive level, so no spurious frame start follows reset.
- Frame start (fs): a single-cycle pulse when registered vs moves from inactive to active per VS_POL. fs is detected one cycle after the vs edge.
- State machine:
  - IDLE: no pending write. An accepted write goes to PEND.
  - PEND: waits for fs. On fs goes to COMMIT.
  - COMMIT: lasts one cycle. Active set <= shadow set, then returns to IDLE.
- Writes:
  - cfg_ready=0 only in COMMIT; 1 otherwise.
  - An accepted write updates its shadow register on the same edge.
  - Writes to addr 6/7 are accepted and have no effect; they do not enter PEND.
  - Writes in PEND are accepted and merged into the shadow set.
  - A write held across COMMIT is accepted in the following cycle and triggers a new PEND.
- cfg_pending = (state != IDLE).
- Active outputs are registered and change only on the COMMIT cycle edge. Latency from fs to new active values is 1 cycle.
- Pixel counter:
  - Each cycle with thr_de & thr_data, the accumulator increments, saturating at all-ones.
  - On fs: fg_count <= accumulator, fg_valid pulses, accumulator clears.
  - If a pixel is counted in the fs cycle, the accumulator restarts at 1 instead of 0.
- The first fs after reset reports the partial frame; the bench ignores that first fg_valid.
- Simultaneous events:
  - fs while in IDLE with an accepted write in the same cycle: the write goes to PEND. It commits on the next fs, not the current one.
- Reset mid-PEND discards the pending shadow writes.

Optional Feature:
- Macro: THR_MINMAX_CHECK_EN.
- Defined: at COMMIT, each channel whose shadow min > shadow max keeps its previous active pair, and cfg_err pulses in the COMMIT cycle. Valid channels still commit. The rejected shadow pair is overwritten with the active pair, so cfg_pending returns to 0.
- Undefined: all pairs commit unconditionally and cfg_err is tied to 0.

Decomposition:
- Shared package thr_pkg holds:
  - Channel widths R_W=5, G_W=6, B_W=5.
  - Address constants ADDR_R_MIN through ADDR_B_MAX.
  - typedef thr_set_t, a packed struct of six fields, used for both shadow and active sets.
  - State enum {IDLE, PEND, COMMIT}.
- One natural sub-module: thr_frame_counter (vs edge detect, fs generation, saturating accumulator, fg_count/fg_valid). Its fs output feeds the controller FSM.

Test Plan:
- Reset, VS_POL=1:
  - Required: outputs r 0/6, g 0/12, b 0/6; cfg_pending=0; cfg_ready=1.
- Write addr3=20 mid-frame:
  - Required: g_max stays 12 and cfg_pending=1 until fs.
  - Required: g_max=20 exactly 1 cycle after fs; cfg_pending=0.
- Frame with 37 cycles of thr_de&thr_data and 10 cycles of thr_data without thr_de:
  - Required: on the next fs, fg_valid pulses once and fg_count=37.
- CNT_W=4, 20 foreground pixels in one frame:
  - Required: fg_count=15 (saturated).
- cfg_valid held through the COMMIT cycle:
  - Required: cfg_ready=0 for exactly 1 cycle; write accepted next cycle; cfg_pending re-asserts.
- THR_MINMAX_CHECK_EN defined; write r_min=10, r_max=3, b_max=9; then fs:
  - Required: red stays 0/6; b_max=9; cfg_err pulses once.
  - Without the macro: red becomes 10/3.
